qa_update_pipe: RTL

- Parametrised, fully pipelined Q-learning Bellman update engine: Qnew = Qsel + alpha*(R + gamma*max(Qnext) - Qsel).
- Supersedes the fixed 4-action, 32-bit updater. Adds:
  - configurable action count and data width;
  - internal argmax over the next-state row;
  - valid tracking through the pipeline;
  - terminal-state handling;
  - saturation with an event counter;
  - out-of-range action detection.
- Sits between the Q-table read port and the Q-table write-back port in the traffic-light learning agent.

---
 rtl/qa_update_pipe_if.sv | 34 +++
 rtl/qa_update_pipe.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qa_update_pipe_if.sv
// Transaction bus for the Q-learning update pipe: the Q-table read side drives
// the request fields, the pipe returns the write-back value and status.
interface qa_update_pipe_if #(
    parameter int NUM_ACT = 4,
    parameter int W       = 32,
    parameter int COEF_W  = 3,
    parameter int ACT_W   = (NUM_ACT > 1) ? $clog2(NUM_ACT) : 1
);
    logic                   in_valid;
    logic [NUM_ACT*W-1:0]   q_cur;
    logic [NUM_ACT*W-1:0]   q_next;
    logic [ACT_W-1:0]       act;
    logic [W-1:0]           reward;
    logic                   done;
    logic [COEF_W-1:0]      alpha;
    logic [COEF_W-1:0]      gamma;

    logic                   out_valid;
    logic [W-1:0]           q_new;
    logic [ACT_W-1:0]       out_act;
    logic [ACT_W-1:0]       out_amax;
    logic                   out_err;
    logic [15:0]            sat_cnt;

    modport master (
        output in_valid, q_cur, q_next, act, reward, done, alpha, gamma,
        input  out_valid, q_new, out_act, out_amax, out_err, sat_cnt
    );

    modport slave (
        input  in_valid, q_cur, q_next, act, reward, done, alpha, gamma,
        output out_valid, q_new, out_act, out_amax, out_err, sat_cnt
    );
endinterface

// File: rtl/qa_update_pipe.sv
// Fully pipelined Bellman update: Qnew = Qsel + alpha*(R + gamma*max(Qnext) - Qsel).
// Seven register ranks (input capture, five arithmetic stages, output) give a
// fixed latency of six cycles from the in_valid sampling edge to out_valid.
module qa_update_pipe #(
    parameter int NUM_ACT = 4,
    parameter int W       = 32,
    parameter int COEF_W  = 3,
    parameter int ACT_W   = (NUM_ACT > 1) ? $clog2(NUM_ACT) : 1
) (
    input logic             clk,
    input logic             rst,
    qa_update_pipe_if.slave bus
);
    localparam int TD_W = W + 2;
    localparam int S_W  = W + 3;
    localparam int GP_W = W + COEF_W;
    localparam int PP_W = TD_W + COEF_W;
    localparam logic signed [S_W-1:0] SMAX = {4'b0000, {(W-1){1'b1}}};
    localparam logic signed [S_W-1:0] SMIN = {4'b1111, {(W-1){1'b0}}};

    // Stage 1: raw transaction
    logic                       s1_valid_d, s1_valid_q;
    logic [NUM_ACT*W-1:0]       s1_q_cur_d, s1_q_cur_q;
    logic [NUM_ACT*W-1:0]       s1_q_next_d, s1_q_next_q;
    logic [ACT_W-1:0]           s1_act_d, s1_act_q;
    logic signed [W-1:0]        s1_rew_d, s1_rew_q;
    logic                       s1_done_d, s1_done_q;
    logic [COEF_W-1:0]          s1_alpha_d, s1_alpha_q;
    logic [COEF_W-1:0]          s1_gamma_d, s1_gamma_q;
    // Stage 2: row reductions
    logic                       s2_valid_d, s2_valid_q;
    logic signed [W-1:0]        s2_qmax_d, s2_qmax_q;
    logic [ACT_W-1:0]           s2_amax_d, s2_amax_q;
    logic signed [W-1:0]        s2_qsel_d, s2_qsel_q;
    logic                       s2_err_d, s2_err_q;
    logic [ACT_W-1:0]           s2_act_d, s2_act_q;
    logic signed [W-1:0]        s2_rew_d, s2_rew_q;
    logic                       s2_done_d, s2_done_q;
    logic [COEF_W-1:0]          s2_alpha_d, s2_alpha_q;
    logic [COEF_W-1:0]          s2_gamma_d, s2_gamma_q;
    // Stage 3: discounted future value
    logic                       s3_valid_d, s3_valid_q;
    logic signed [W-1:0]        s3_g_d, s3_g_q;
    logic signed [W-1:0]        s3_rew_d, s3_rew_q;
    logic signed [W-1:0]        s3_qsel_d, s3_qsel_q;
    logic                       s3_err_d, s3_err_q;
    logic [ACT_W-1:0]           s3_act_d, s3_act_q;
    logic [ACT_W-1:0]           s3_amax_d, s3_amax_q;
    logic [COEF_W-1:0]          s3_alpha_d, s3_alpha_q;
    // Stage 4: temporal difference
    logic                       s4_valid_d, s4_valid_q;
    logic signed [TD_W-1:0]     s4_td_d, s4_td_q;
    logic signed [W-1:0]        s4_qsel_d, s4_qsel_q;
    logic                       s4_err_d, s4_err_q;
    logic [ACT_W-1:0]           s4_act_d, s4_act_q;
    logic [ACT_W-1:0]           s4_amax_d, s4_amax_q;
    logic [COEF_W-1:0]          s4_alpha_d, s4_alpha_q;
    // Stage 5: scaled correction
    logic                       s5_valid_d, s5_valid_q;
    logic signed [TD_W-1:0]     s5_p_d, s5_p_q;
    logic signed [W-1:0]        s5_qsel_d, s5_qsel_q;
    logic                       s5_err_d, s5_err_q;
    logic [ACT_W-1:0]           s5_act_d, s5_act_q;
    logic [ACT_W-1:0]           s5_amax_d, s5_amax_q;
    // Stage 6: unsaturated sum
    logic                       s6_valid_d, s6_valid_q;
    logic signed [S_W-1:0]      s6_sum_d, s6_sum_q;
    logic                       s6_err_d, s6_err_q;
    logic [ACT_W-1:0]           s6_act_d, s6_act_q;
    logic [ACT_W-1:0]           s6_amax_d, s6_amax_q;
    // Output rank
    logic                       out_valid_d, out_valid_q;
    logic [W-1:0]               q_new_d, q_new_q;
    logic [ACT_W-1:0]           out_act_d, out_act_q;
    logic [ACT_W-1:0]           out_amax_d, out_amax_q;
    logic                       out_err_d, out_err_q;
    logic [15:0]                sat_cnt_d, sat_cnt_q;
    // Combinational helpers
    logic signed [W-1:0]        qmax_c;
    logic [ACT_W-1:0]           amax_c;
    logic signed [W-1:0]        qsel_c;
    logic                       err_c;
    logic signed [GP_W-1:0]     gprod_c;
    logic signed [GP_W-1:0]     gshift_c;
    logic signed [PP_W-1:0]     pprod_c;
    logic signed [PP_W-1:0]     pshift_c;
    logic                       sat_hit_c;

    // Capture a new transaction; data holds during bubbles so idle cycles do not toggle the datapath.
    always_comb begin
        s1_valid_d  = bus.in_valid;
        s1_q_cur_d  = s1_q_cur_q;
        s1_q_next_d = s1_q_next_q;
        s1_act_d    = s1_act_q;
        s1_rew_d    = s1_rew_q;
        s1_done_d   = s1_done_q;
        s1_alpha_d  = s1_alpha_q;
        s1_gamma_d  = s1_gamma_q;
        if (bus.in_valid) begin
            s1_q_cur_d  = bus.q_cur;
            s1_q_next_d = bus.q_next;
            s1_act_d    = bus.act;
            s1_rew_d    = bus.reward;
            s1_done_d   = bus.done;
            s1_alpha_d  = bus.alpha;
            s1_gamma_d  = bus.gamma;
        end
    end

    // Argmax of the next-state row (strict > keeps the lowest index on ties) and selection of Q(s,a).
    always_comb begin
        qmax_c = s1_q_next_q[W-1:0];
        amax_c = '0;
        for (int i = 1; i < NUM_ACT; i++) begin
            if ($signed(s1_q_next_q[i*W +: W]) > qmax_c) begin
                qmax_c = s1_q_next_q[i*W +: W];
                amax_c = ACT_W'(i);
            end
        end
        qsel_c = '0;
        err_c  = 1'b1;
        for (int i = 0; i < NUM_ACT; i++) begin
            if (s1_act_q == ACT_W'(i)) begin
                qsel_c = s1_q_cur_q[i*W +: W];
                err_c  = 1'b0;
            end
        end
        s2_valid_d = s1_valid_q;
        s2_qmax_d  = s2_qmax_q;
        s2_amax_d  = s2_amax_q;
        s2_qsel_d  = s2_qsel_q;
        s2_err_d   = s2_err_q;
        s2_act_d   = s2_act_q;
        s2_rew_d   = s2_rew_q;
        s2_done_d  = s2_done_q;
        s2_alpha_d = s2_alpha_q;
        s2_gamma_d = s2_gamma_q;
        if (s1_valid_q) begin
            s2_qmax_d  = qmax_c;
            s2_amax_d  = amax_c;
            s2_qsel_d  = qsel_c;
            s2_err_d   = err_c;
            s2_act_d   = s1_act_q;
            s2_rew_d   = s1_rew_q;
            s2_done_d  = s1_done_q;
            s2_alpha_d = s1_alpha_q;
            s2_gamma_d = s1_gamma_q;
        end
    end

    // Discounted max: gamma is a fraction below one, so the floored product always fits in W bits.
    always_comb begin
        gprod_c    = GP_W'($signed({1'b0, s2_gamma_q})) * GP_W'(s2_qmax_q);
        gshift_c   = gprod_c >>> COEF_W;
        s3_valid_d = s2_valid_q;
        s3_g_d     = s3_g_q;
        s3_rew_d   = s3_rew_q;
        s3_qsel_d  = s3_qsel_q;
        s3_err_d   = s3_err_q;
        s3_act_d   = s3_act_q;
        s3_amax_d  = s3_amax_q;
        s3_alpha_d = s3_alpha_q;
        if (s2_valid_q) begin
            s3_g_d     = s2_done_q ? '0 : gshift_c[W-1:0];
            s3_rew_d   = s2_rew_q;
            s3_qsel_d  = s2_qsel_q;
            s3_err_d   = s2_err_q;
            s3_act_d   = s2_act_q;
            s3_amax_d  = s2_amax_q;
            s3_alpha_d = s2_alpha_q;
        end
    end

    // Temporal difference at two extra bits, wide enough for any combination of W-bit operands.
    always_comb begin
        s4_valid_d = s3_valid_q;
        s4_td_d    = s4_td_q;
        s4_qsel_d  = s4_qsel_q;
        s4_err_d   = s4_err_q;
        s4_act_d   = s4_act_q;
        s4_amax_d  = s4_amax_q;
        s4_alpha_d = s4_alpha_q;
        if (s3_valid_q) begin
            s4_td_d    = TD_W'(s3_rew_q) + TD_W'(s3_g_q) - TD_W'(s3_qsel_q);
            s4_qsel_d  = s3_qsel_q;
            s4_err_d   = s3_err_q;
            s4_act_d   = s3_act_q;
            s4_amax_d  = s3_amax_q;
            s4_alpha_d = s3_alpha_q;
        end
    end

    // Learning-rate scaling, floored back to the TD width.
    always_comb begin
        pprod_c    = PP_W'($signed({1'b0, s4_alpha_q})) * PP_W'(s4_td_q);
        pshift_c   = pprod_c >>> COEF_W;
        s5_valid_d = s4_valid_q;
        s5_p_d     = s5_p_q;
        s5_qsel_d  = s5_qsel_q;
        s5_err_d   = s5_err_q;
        s5_act_d   = s5_act_q;
        s5_amax_d  = s5_amax_q;
        if (s4_valid_q) begin
            s5_p_d    = pshift_c[TD_W-1:0];
            s5_qsel_d = s4_qsel_q;
            s5_err_d  = s4_err_q;
            s5_act_d  = s4_act_q;
            s5_amax_d = s4_amax_q;
        end
    end

    // Full-precision sum of the old value and the correction, saturated one rank later.
    always_comb begin
        s6_valid_d = s5_valid_q;
        s6_sum_d   = s6_sum_q;
        s6_err_d   = s6_err_q;
        s6_act_d   = s6_act_q;
        s6_amax_d  = s6_amax_q;
        if (s5_valid_q) begin
            s6_sum_d  = S_W'(s5_qsel_q) + S_W'(s5_p_q);
            s6_err_d  = s5_err_q;
            s6_act_d  = s5_act_q;
            s6_amax_d = s5_amax_q;
        end
    end

    // Clamp into W bits, force zero on a bad action, and count clamped results up to a sticky maximum.
    always_comb begin
        out_valid_d = s6_valid_q;
        q_new_d     = q_new_q;
        out_act_d   = out_act_q;
        out_amax_d  = out_amax_q;
        out_err_d   = out_err_q;
        sat_hit_c   = 1'b0;
        if (s6_valid_q) begin
            out_act_d  = s6_act_q;
            out_amax_d = s6_amax_q;
            out_err_d  = s6_err_q;
            if (s6_err_q) begin
                q_new_d = '0;
            end else if (s6_sum_q > SMAX) begin
                q_new_d   = {1'b0, {(W-1){1'b1}}};
                sat_hit_c = 1'b1;
            end else if (s6_sum_q < SMIN) begin
                q_new_d   = {1'b1, {(W-1){1'b0}}};
                sat_hit_c = 1'b1;
            end else begin
                q_new_d = s6_sum_q[W-1:0];
            end
        end
        sat_cnt_d = sat_cnt_q;
        if (sat_hit_c && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    // Pipeline registers; reset empties the pipe and clears every output.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0; s1_q_cur_q <= '0; s1_q_next_q <= '0; s1_act_q <= '0;
            s1_rew_q <= '0; s1_done_q <= 1'b0; s1_alpha_q <= '0; s1_gamma_q <= '0;
            s2_valid_q <= 1'b0; s2_qmax_q <= '0; s2_amax_q <= '0; s2_qsel_q <= '0;
            s2_err_q <= 1'b0; s2_act_q <= '0; s2_rew_q <= '0; s2_done_q <= 1'b0;
            s2_alpha_q <= '0; s2_gamma_q <= '0;
            s3_valid_q <= 1'b0; s3_g_q <= '0; s3_rew_q <= '0; s3_qsel_q <= '0;
            s3_err_q <= 1'b0; s3_act_q <= '0; s3_amax_q <= '0; s3_alpha_q <= '0;
            s4_valid_q <= 1'b0; s4_td_q <= '0; s4_qsel_q <= '0; s4_err_q <= 1'b0;
            s4_act_q <= '0; s4_amax_q <= '0; s4_alpha_q <= '0;
            s5_valid_q <= 1'b0; s5_p_q <= '0; s5_qsel_q <= '0; s5_err_q <= 1'b0;
            s5_act_q <= '0; s5_amax_q <= '0;
            s6_valid_q <= 1'b0; s6_sum_q <= '0; s6_err_q <= 1'b0; s6_act_q <= '0; s6_amax_q <= '0;
            out_valid_q <= 1'b0; q_new_q <= '0; out_act_q <= '0; out_amax_q <= '0;
            out_err_q <= 1'b0; sat_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d; s1_q_cur_q <= s1_q_cur_d; s1_q_next_q <= s1_q_next_d;
            s1_act_q <= s1_act_d; s1_rew_q <= s1_rew_d; s1_done_q <= s1_done_d;
            s1_alpha_q <= s1_alpha_d; s1_gamma_q <= s1_gamma_d;
            s2_valid_q <= s2_valid_d; s2_qmax_q <= s2_qmax_d; s2_amax_q <= s2_amax_d;
            s2_qsel_q <= s2_qsel_d; s2_err_q <= s2_err_d; s2_act_q <= s2_act_d;
            s2_rew_q <= s2_rew_d; s2_done_q <= s2_done_d; s2_alpha_q <= s2_alpha_d;
            s2_gamma_q <= s2_gamma_d;
            s3_valid_q <= s3_valid_d; s3_g_q <= s3_g_d; s3_rew_q <= s3_rew_d;
            s3_qsel_q <= s3_qsel_d; s3_err_q <= s3_err_d; s3_act_q <= s3_act_d;
            s3_amax_q <= s3_amax_d; s3_alpha_q <= s3_alpha_d;
            s4_valid_q <= s4_valid_d; s4_td_q <= s4_td_d; s4_qsel_q <= s4_qsel_d;
            s4_err_q <= s4_err_d; s4_act_q <= s4_act_d; s4_amax_q <= s4_amax_d;
            s4_alpha_q <= s4_alpha_d;
            s5_valid_q <= s5_valid_d; s5_p_q <= s5_p_d; s5_qsel_q <= s5_qsel_d;
            s5_err_q <= s5_err_d; s5_act_q <= s5_act_d; s5_amax_q <= s5_amax_d;
            s6_valid_q <= s6_valid_d; s6_sum_q <= s6_sum_d; s6_err_q <= s6_err_d;
            s6_act_q <= s6_act_d; s6_amax_q <= s6_amax_d;
            out_valid_q <= out_valid_d; q_new_q <= q_new_d; out_act_q <= out_act_d;
            out_amax_q <= out_amax_d; out_err_q <= out_err_d; sat_cnt_q <= sat_cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.q_new     = q_new_q;
    assign bus.out_act   = out_act_q;
    assign bus.out_amax  = out_amax_q;
    assign bus.out_err   = out_err_q;
    assign bus.sat_cnt   = sat_cnt_q;
endmodule
